reg_writeback: RTL and testbench
================================

# reg_writeback

Write-back stage for the single-issue RV32I core: the write side of the register file. It accepts one retired instruction per cycle from execute, fetches load data from data memory over a req/ack handshake, and byte/halfword-extracts it. It drives the register file's `RegWrite`/`rd`/`write_data` port as a registered one-cycle pulse; non-writing instructions retire silently.

## Interface
- `TIMEOUT`, 255: max cycles `mem_req` may stay high without `mem_ack` (1..65535); the counter is 16 bits.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: execute presents an instruction result.
- `in_ready` out 1: stage can accept. An instruction is accepted on a cycle where `in_valid && in_ready`.
- `inst` in 32: instruction word; uses `[6:0]` opcode, `[14:12]` funct3, `[11:7]` rd.
- `alu_result` in 32: ALU result; for loads, the byte address.
- `pc_plus4` in 32: link value for JAL/JALR.
- `mem_req` out 1: load read request.
- `mem_addr` out 32: word address, `{alu_result[31:2],2'b00}`.
- `mem_ack` in 1: read data valid.
- `mem_rdata` in 32: read word, little-endian.
- `RegWrite` out 1: register write strobe, one-cycle pulse.
- `rd_addr` out 5: destination register.
- `write_data` out 32: value to write.
- `err` out 1: one-cycle pulse on misaligned load or memory timeout.

## Operation
**States:** IDLE, MEM_WAIT.

**IDLE**
- `in_ready=1`; `in_ready=0` while `rst` is high.
- Opcode 0110011/0010011/0110111 (R, I-ALU, LUI): `write_data=alu_result`.
- Opcode 1101111/1100111 (JAL/JALR): `write_data=pc_plus4`.
- Opcode 0100011/1100011 (store, branch) or any other opcode: retire with no write.
- Opcode 0000011 (load):
  - If funct3 ∈ {001,101} and `addr[0]=1`, or funct3=010 and `addr[1:0]≠0`: misaligned. Pulse `err` next cycle, no write, stay IDLE.
  - Otherwise latch rd, funct3 and `addr[1:0]`, drive `mem_req=1` and `mem_addr`, clear the counter, and go to MEM_WAIT.
- rd=0: never pulse `RegWrite`. A load to x0 still performs the memory read.

**MEM_WAIT**
- `in_ready=0`; `mem_req` and `mem_addr` held stable.
- `mem_ack` high: drop `mem_req` next cycle, extract, pulse `RegWrite` next cycle, return to IDLE.
- No ack: increment the counter. When the counter reaches TIMEOUT−1 without an ack, drop `mem_req` and pulse `err` next cycle, with no write, and return to IDLE.
- Ack on the timeout cycle wins; no `err`.

**Load extraction** (lane selected by latched `addr[1:0]`)
- 000 lb: sign-extend the selected byte.
- 100 lbu: zero-extend the selected byte.
- 001 lh: sign-extend `addr[1]`'s halfword.
- 101 lhu: zero-extend `addr[1]`'s halfword.
- 010 lw: whole word.
- funct3 011/110/111: treated as a misaligned-class error.

**Other rules**
- `mem_ack` while not in MEM_WAIT is ignored.
- `rd_addr` and `write_data` hold their last values between pulses. `RegWrite` is 0 except during a pulse.
- Reset mid-operation: drop the pending load, return to IDLE, and never write.

## Timing
- Reset values: `mem_req=0`, `mem_addr=0`, `RegWrite=0`, `rd_addr=0`, `write_data=0`, `err=0`, state IDLE, counter 0.
- Non-load: accepted at cycle T, `RegWrite` at T+1. Throughput is one per cycle; back-to-back pulses are allowed.
- Load:
  - Accepted at T, `mem_req` high from T+1.
  - Ack at cycle A ≥ T+1 gives `RegWrite` at A+1, `mem_req` low at A+1, `in_ready` high at A+1.
  - Minimum latency is 2 cycles.
- Timeout: `mem_req` high for exactly TIMEOUT cycles; `err` in the cycle after.
- `in_ready` is combinational from state.
- `err` and `RegWrite` are never high in the same cycle.

## Test plan
- ADDI x5 with `alu_result=0x0000_0123` accepted at T → `RegWrite=1`, `rd_addr=5`, `write_data=0x123` at T+1, single cycle.
- lb x6, `addr=0x1003`, ack at T+1 with `mem_rdata=0x80AB_CDEF` → `mem_addr=0x1000`, `write_data=0xFFFF_FF80` at T+2.
- lhu x7, `addr=0x2002`, ack at T+4 with `mem_rdata=0x8001_0000` → `write_data=0x0000_8001` at T+5. `in_ready` is low T+1..T+4.
- lw at `addr=0x3001` → `err` pulse at T+1, no `mem_req`, no `RegWrite`. JAL x0 → no `RegWrite`.
- TIMEOUT=4, lw with no ack → `mem_req` high T+1..T+4, `err` at T+5, no write. Repeat with ack at T+4 → write at T+5, no `err`.
- Load pending at T+2, `rst` high at T+3 → all outputs 0 at T+4. A late `mem_ack` at T+5 is ignored, with no `RegWrite`.

Source files
------------

// File: rtl/reg_writeback.sv
// Write-back stage: registers the register-file write port and services loads over a
// req/ack data-memory handshake with byte/halfword extraction and a request timeout.
module reg_writeback #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] alu_result,
    input  logic [31:0] pc_plus4,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        RegWrite,
    output logic [4:0]  rd_addr,
    output logic [31:0] write_data,
    output logic        err
);

    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpImm  = 7'b0010011;
    localparam logic [6:0] OpLui  = 7'b0110111;
    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [6:0] OpJalr = 7'b1100111;
    localparam logic [6:0] OpLoad = 7'b0000011;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    // Last counter value before the request is abandoned.
    localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        StIdle,
        StMemWait
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [2:0]  ld_funct3_q, ld_funct3_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] write_data_q, write_data_d;
    logic        err_q, err_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        accept;
    logic        ld_bad;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;
    logic        unused_inst;

    assign opcode      = inst[6:0];
    assign funct3      = inst[14:12];
    assign rd          = inst[11:7];
    assign unused_inst = ^inst[31:15];

    assign in_ready = (state_q == StIdle) && !rst;
    assign accept   = in_valid && in_ready;

    // Unsupported load widths are reported through the same path as misalignment.
    always_comb begin
        ld_bad = 1'b1;
        unique case (funct3)
            F3Lb, F3Lbu: ld_bad = 1'b0;
            F3Lh, F3Lhu: ld_bad = alu_result[0];
            F3Lw:        ld_bad = |alu_result[1:0];
            default:     ld_bad = 1'b1;
        endcase
    end

    always_comb begin
        lane_byte = mem_rdata[7:0];
        unique case (ld_off_q)
            2'd0: lane_byte = mem_rdata[7:0];
            2'd1: lane_byte = mem_rdata[15:8];
            2'd2: lane_byte = mem_rdata[23:16];
            2'd3: lane_byte = mem_rdata[31:24];
        endcase
        lane_half = ld_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        load_data = mem_rdata;
        unique case (ld_funct3_q)
            F3Lb:    load_data = {{24{lane_byte[7]}}, lane_byte};
            F3Lbu:   load_data = {24'd0, lane_byte};
            F3Lh:    load_data = {{16{lane_half[15]}}, lane_half};
            F3Lhu:   load_data = {16'd0, lane_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        ld_rd_d      = ld_rd_q;
        ld_funct3_d  = ld_funct3_q;
        ld_off_d     = ld_off_q;
        reg_write_d  = 1'b0;
        rd_addr_d    = rd_addr_q;
        write_data_d = write_data_q;
        err_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (opcode)
                        OpR, OpImm, OpLui: begin
                            if (rd != 5'd0) begin
                                reg_write_d  = 1'b1;
                                rd_addr_d    = rd;
                                write_data_d = alu_result;
                            end
                        end
                        OpJal, OpJalr: begin
                            if (rd != 5'd0) begin
                                reg_write_d  = 1'b1;
                                rd_addr_d    = rd;
                                write_data_d = pc_plus4;
                            end
                        end
                        OpLoad: begin
                            if (ld_bad) begin
                                err_d = 1'b1;
                            end else begin
                                // x0 loads still issue the read; the write is suppressed later.
                                ld_rd_d     = rd;
                                ld_funct3_d = funct3;
                                ld_off_d    = alu_result[1:0];
                                mem_req_d   = 1'b1;
                                mem_addr_d  = {alu_result[31:2], 2'b00};
                                cnt_d       = 16'd0;
                                state_d     = StMemWait;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StMemWait: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                    if (ld_rd_q != 5'd0) begin
                        reg_write_d  = 1'b1;
                        rd_addr_d    = ld_rd_q;
                        write_data_d = load_data;
                    end
                end else if (cnt_q == CntLast) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 16'd0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= 32'd0;
            ld_rd_q      <= 5'd0;
            ld_funct3_q  <= 3'd0;
            ld_off_q     <= 2'd0;
            reg_write_q  <= 1'b0;
            rd_addr_q    <= 5'd0;
            write_data_q <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            ld_rd_q      <= ld_rd_d;
            ld_funct3_q  <= ld_funct3_d;
            ld_off_q     <= ld_off_d;
            reg_write_q  <= reg_write_d;
            rd_addr_q    <= rd_addr_d;
            write_data_q <= write_data_d;
            err_q        <= err_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign RegWrite   = reg_write_q;
    assign rd_addr    = rd_addr_q;
    assign write_data = write_data_q;
    assign err        = err_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: the driver queues expected write/err pulses,
// an independent monitor pops and compares them whenever the DUT pulses an output.
module tb_reg_writeback;

    localparam int unsigned TIMEOUT = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        RegWrite;
    logic [4:0]  rd_addr;
    logic [31:0] write_data;
    logic        err;

    always #5 clk = ~clk;

    reg_writeback #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .inst       (inst),
        .alu_result (alu_result),
        .pc_plus4   (pc_plus4),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .RegWrite   (RegWrite),
        .rd_addr    (rd_addr),
        .write_data (write_data),
        .err        (err)
    );

    typedef struct {
        logic        is_err;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fails  = 0;
    bit   mon_en   = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] rd);
        return {17'd0, f3, rd, op};
    endfunction

    function automatic void push_write(input logic [4:0] rd, input logic [31:0] data);
        exp_t x;
        x.is_err = 1'b0;
        x.rd     = rd;
        x.data   = data;
        exp_q.push_back(x);
    endfunction

    function automatic void push_err();
        exp_t x;
        x.is_err = 1'b1;
        x.rd     = 5'd0;
        x.data   = 32'd0;
        exp_q.push_back(x);
    endfunction

    // Monitor: every pulse must match the oldest expectation; unexpected pulses fail.
    always @(negedge clk) begin
        if (mon_en && (RegWrite || err)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_pulse: got RegWrite=%0b err=%0b rd=%0d data=0x%08h, required none",
                         RegWrite, err, rd_addr, write_data);
            end else begin
                e = exp_q.pop_front();
                check("pulse_err", {31'd0, err}, {31'd0, e.is_err});
                check("pulse_regwrite", {31'd0, RegWrite}, {31'd0, !e.is_err});
                if (!e.is_err) begin
                    check("pulse_rd_addr", {27'd0, rd_addr}, {27'd0, e.rd});
                    check("pulse_write_data", write_data, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] i, input logic [31:0] alu, input logic [31:0] pc4);
        in_valid   = 1'b1;
        inst       = i;
        alu_result = alu;
        pc_plus4   = pc4;
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // ack_at = k acks in cycle T+k; ack_at = 0 never acks (timeout).
    task automatic do_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                           input int ack_at, input logic [31:0] rdata);
        int last;
        last = (ack_at == 0) ? int'(TIMEOUT) : ack_at;
        issue(mk(OP_LOAD, f3, rd), addr, 32'h0);
        for (int j = 1; j <= last; j++) begin
            mem_ack   = (j == ack_at);
            mem_rdata = (j == ack_at) ? rdata : 32'h5A5A_0000 + 32'(j);
            @(negedge clk);
            check("mem_req_wait", {31'd0, mem_req}, 32'd1);
            check("mem_addr", mem_addr, {addr[31:2], 2'b00});
            check("in_ready_wait", {31'd0, in_ready}, 32'd0);
            tick();
        end
        mem_ack = 1'b0;
        @(negedge clk);
        check("mem_req_done", {31'd0, mem_req}, 32'd0);
        check("in_ready_done", {31'd0, in_ready}, 32'd1);
        tick();
    endtask

    task automatic bad_load(input logic [2:0] f3, input logic [31:0] addr);
        push_err();
        issue(mk(OP_LOAD, f3, 5'd20), addr, 32'h0);
        @(negedge clk);
        check("mem_req_misaligned", {31'd0, mem_req}, 32'd0);
        check("in_ready_misaligned", {31'd0, in_ready}, 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        inst       = 32'd0;
        alu_result = 32'd0;
        pc_plus4   = 32'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        repeat (2) tick();
        @(negedge clk);
        check("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_regwrite", {31'd0, RegWrite}, 32'd0);
        check("reset_rd_addr", {27'd0, rd_addr}, 32'd0);
        check("reset_write_data", write_data, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        tick();
        rst    = 1'b0;
        mon_en = 1'b1;

        // ADDI x5, then confirm single-cycle pulse and held rd/data.
        push_write(5'd5, 32'h0000_0123);
        issue(mk(OP_IMM, 3'b000, 5'd5), 32'h0000_0123, 32'h0);
        tick();
        @(negedge clk);
        check("hold_regwrite_low", {31'd0, RegWrite}, 32'd0);
        check("hold_rd_addr", {27'd0, rd_addr}, 32'd5);
        check("hold_write_data", write_data, 32'h0000_0123);
        tick();

        // Back-to-back non-load writes, then silent retirements.
        push_write(5'd1, 32'hABCD_E000);
        issue(mk(OP_LUI, 3'b000, 5'd1), 32'hABCD_E000, 32'h0);
        push_write(5'd2, 32'h0000_0104);
        issue(mk(OP_JAL, 3'b000, 5'd2), 32'h1111_1111, 32'h0000_0104);
        push_write(5'd4, 32'h0000_0208);
        issue(mk(OP_JALR, 3'b000, 5'd4), 32'h2222_2222, 32'h0000_0208);
        push_write(5'd3, 32'h0000_0055);
        issue(mk(OP_R, 3'b000, 5'd3), 32'h0000_0055, 32'h0);
        issue(mk(OP_STORE, 3'b010, 5'd9), 32'h3333_3333, 32'h0);
        issue(mk(OP_BRANCH, 3'b000, 5'd9), 32'h4444_4444, 32'h0);
        issue(mk(OP_FENCE, 3'b000, 5'd9), 32'h5555_5555, 32'h0);
        issue(mk(OP_JAL, 3'b000, 5'd0), 32'h0, 32'h0000_0300);
        issue(mk(OP_IMM, 3'b000, 5'd0), 32'h0000_0777, 32'h0);
        tick();

        // Loads with extraction across lanes and ack latencies.
        push_write(5'd6, 32'hFFFF_FF80);
        do_load(3'b000, 5'd6, 32'h0000_1003, 1, 32'h80AB_CDEF);
        push_write(5'd7, 32'h0000_8001);
        do_load(3'b101, 5'd7, 32'h0000_2002, 4, 32'h8001_0000);
        push_write(5'd9, 32'hFFFF_8001);
        do_load(3'b001, 5'd9, 32'h0000_5002, 2, 32'h8001_7FFF);
        push_write(5'd12, 32'hFFFF_8765);
        do_load(3'b001, 5'd12, 32'h0000_5000, 1, 32'h1234_8765);
        push_write(5'd10, 32'h0000_00F0);
        do_load(3'b100, 5'd10, 32'h0000_6001, 1, 32'h1234_F078);
        push_write(5'd11, 32'hFFFF_FFB4);
        do_load(3'b000, 5'd11, 32'h0000_6002, 3, 32'h12B4_F078);
        push_write(5'd14, 32'hDEAD_BEEF);
        do_load(3'b010, 5'd14, 32'h0000_7000, 2, 32'hDEAD_BEEF);

        // Timeout, then ack on the timeout cycle.
        push_err();
        do_load(3'b010, 5'd8, 32'h0000_4000, 0, 32'h0);
        push_write(5'd16, 32'hCAFE_F00D);
        do_load(3'b010, 5'd16, 32'h0000_4004, int'(TIMEOUT), 32'hCAFE_F00D);

        // Load to x0 still requests memory but never writes.
        do_load(3'b010, 5'd0, 32'h0000_8000, 1, 32'h1234_5678);

        // Misaligned and unsupported loads.
        bad_load(3'b010, 32'h0000_3001);
        bad_load(3'b001, 32'h0000_5001);
        bad_load(3'b101, 32'h0000_5003);
        bad_load(3'b011, 32'h0000_0000);
        bad_load(3'b110, 32'h0000_0000);

        // Stray ack while idle.
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        repeat (2) tick();
        mem_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_mem_req", {31'd0, mem_req}, 32'd0);
        tick();

        // Reset while a load is pending; late ack must be ignored.
        issue(mk(OP_LOAD, 3'b010, 5'd13), 32'h0000_9000, 32'h0);
        tick();
        @(negedge clk);
        check("pending_mem_req", {31'd0, mem_req}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midreset_mem_req", {31'd0, mem_req}, 32'd0);
        check("midreset_mem_addr", mem_addr, 32'd0);
        check("midreset_regwrite", {31'd0, RegWrite}, 32'd0);
        check("midreset_rd_addr", {27'd0, rd_addr}, 32'd0);
        check("midreset_write_data", write_data, 32'd0);
        check("midreset_err", {31'd0, err}, 32'd0);
        check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
        repeat (3) tick();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
